pipeline_hazard_ctrl: RTL and testbench

Central sequencer for the 4-stage pipeline (IF, ID, EX, WB). It watches decode-stage source registers, the ID/EX and EX/WB buffer contents, and branch/jump resolution in WB. It drives the PC and pipeline-buffer write enables, bubble insertion and flushes. A 3-state FSM handles RAW stalls and post-redirect flush windows, and saturating counters report stall cycles and redirects.

---
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/redirect sequencer for the 4-stage IF/ID/EX/WB pipeline.
// Decodes RAW hazards and WB-stage branch resolution into PC/buffer controls.
module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned REG_W        = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             idex_regwrt,
    input  logic [REG_W-1:0] exwb_rd,
    input  logic             exwb_regwrt,
    input  logic             wb_branch,
    input  logic             wb_btype,
    input  logic             wb_jump,
    input  logic             wb_neg,
    input  logic             wb_zero,
    output logic             pc_write,
    output logic             pc_redirect,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exwb,
    output logic [15:0]      stall_cycles,
    output logic [15:0]      redirect_count
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_next;
    logic [2:0] cnt, cnt_next;
    logic       take, hz_ex, hz_wb;
    logic       do_redirect, do_stall, do_flush;

    assign take  = wb_jump | (wb_branch & (wb_btype ? wb_neg : wb_zero));
    assign hz_ex = idex_regwrt & ((id_use_rs & (id_rs == idex_rd)) |
                                  (id_use_rt & (id_rt == idex_rd)));
    assign hz_wb = exwb_regwrt & ((id_use_rs & (id_rs == exwb_rd)) |
                                  (id_use_rt & (id_rt == exwb_rd)));

    // Flush window swallows everything; otherwise a taken redirect beats any hazard.
    assign do_flush    = (state == FLUSH);
    assign do_redirect = !do_flush && take;
    assign do_stall    = !do_flush && !take && ((state == STALL) || hz_ex || hz_wb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            RUN: begin
                if (take) begin
                    state_next = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
                    cnt_next   = FLUSH_INIT;
                end else if (hz_ex) begin
                    state_next = STALL;
                end
            end
            STALL: begin
                if (take) begin
                    state_next = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
                    cnt_next   = FLUSH_INIT;
                end else begin
                    state_next = RUN;
                end
            end
            FLUSH: begin
                if (cnt <= 3'd1) begin
                    state_next = RUN;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = 3'd0;
            end
        endcase
    end

    always_comb begin
        pc_write    = 1'b1;
        pc_redirect = 1'b0;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exwb  = 1'b0;
        if (rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            flush_exwb = 1'b1;
        end else if (do_flush || do_redirect) begin
            pc_redirect = do_redirect;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exwb  = 1'b1;
        end else if (do_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles   <= 16'd0;
            redirect_count <= 16'd0;
        end else begin
            if (do_stall && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (do_redirect && redirect_count != 16'hFFFF)
                redirect_count <= redirect_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl against a
// cycle-level model that tracks owed stall and flush cycles.
module tb_pipeline_hazard_ctrl;

    localparam int FC = 2;
    localparam int RW = 6;

    localparam logic [6:0] OUT_NORMAL   = 7'b1010000;
    localparam logic [6:0] OUT_STALL    = 7'b0001000;
    localparam logic [6:0] OUT_REDIRECT = 7'b1110111;
    localparam logic [6:0] OUT_FLUSH    = 7'b1010111;
    localparam logic [6:0] OUT_RESET    = 7'b0000111;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_rs, id_rt, idex_rd, exwb_rd;
    logic          id_use_rs, id_use_rt, idex_regwrt, exwb_regwrt;
    logic          wb_branch, wb_btype, wb_jump, wb_neg, wb_zero;
    logic          pc_write, pc_redirect, ifid_write, idex_bubble;
    logic          flush_ifid, flush_idex, flush_exwb;
    logic [15:0]   stall_cycles, redirect_count;

    int checks_total  = 0;
    int checks_passed = 0;

    int m_flush_left    = 0;
    bit m_stall_pending = 1'b0;
    int m_stall_cnt     = 0;
    int m_redir_cnt     = 0;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .REG_W(RW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .idex_rd(idex_rd), .idex_regwrt(idex_regwrt),
        .exwb_rd(exwb_rd), .exwb_regwrt(exwb_regwrt),
        .wb_branch(wb_branch), .wb_btype(wb_btype), .wb_jump(wb_jump),
        .wb_neg(wb_neg), .wb_zero(wb_zero),
        .pc_write(pc_write), .pc_redirect(pc_redirect), .ifid_write(ifid_write),
        .idex_bubble(idex_bubble), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_exwb(flush_exwb), .stall_cycles(stall_cycles), .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed === expected)
            checks_passed++;
        else
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                 input logic use_rs, input logic use_rt,
                                 input logic [RW-1:0] e_rd, input logic e_wr,
                                 input logic [RW-1:0] w_rd, input logic w_wr,
                                 input logic br, input logic bt, input logic jp,
                                 input logic ng, input logic zr);
        id_rs = rs; id_rt = rt; id_use_rs = use_rs; id_use_rt = use_rt;
        idex_rd = e_rd; idex_regwrt = e_wr; exwb_rd = w_rd; exwb_regwrt = w_wr;
        wb_branch = br; wb_btype = bt; wb_jump = jp; wb_neg = ng; wb_zero = zr;
    endtask

    task automatic applyIdle();
        applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [6:0] outVec();
        return {pc_write, pc_redirect, ifid_write, idex_bubble, flush_ifid, flush_idex, flush_exwb};
    endfunction

    // Called at a falling edge with inputs driven; checks, then advances the model past the next rising edge.
    task automatic stepCycle(input string tag);
        bit take, hzex, hzwb;
        logic [6:0] exp_out;
        #1;
        take = wb_jump || (wb_branch && (wb_btype ? wb_neg : wb_zero));
        hzex = idex_regwrt && ((id_use_rs && id_rs == idex_rd) || (id_use_rt && id_rt == idex_rd));
        hzwb = exwb_regwrt && ((id_use_rs && id_rs == exwb_rd) || (id_use_rt && id_rt == exwb_rd));
        checkOutput({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_stall_cnt));
        checkOutput({tag, ".redirect_count"}, 32'(redirect_count), 32'(m_redir_cnt));
        if (m_flush_left > 0) begin
            exp_out = OUT_FLUSH;
            m_flush_left--;
        end else if (take) begin
            exp_out = OUT_REDIRECT;
            m_flush_left = FC - 1;
            m_stall_pending = 1'b0;
            if (m_redir_cnt < 65535) m_redir_cnt++;
        end else if (m_stall_pending || hzex || hzwb) begin
            exp_out = OUT_STALL;
            m_stall_pending = !m_stall_pending && hzex;
            if (m_stall_cnt < 65535) m_stall_cnt++;
        end else begin
            exp_out = OUT_NORMAL;
        end
        checkOutput({tag, ".outputs"}, 32'(outVec()), 32'(exp_out));
        @(negedge clk);
    endtask

    // Asserts reset between edges and checks the asynchronous response.
    task automatic doReset(input string tag);
        #2 rst = 1'b1;
        #1;
        checkOutput({tag, ".rst_outputs"}, 32'(outVec()), 32'(OUT_RESET));
        checkOutput({tag, ".rst_stall_cycles"}, 32'(stall_cycles), 32'd0);
        checkOutput({tag, ".rst_redirect_count"}, 32'(redirect_count), 32'd0);
        m_flush_left = 0;
        m_stall_pending = 1'b0;
        m_stall_cnt = 0;
        m_redir_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        applyIdle();
        #2;
        checkOutput("init.rst_outputs", 32'(outVec()), 32'(OUT_RESET));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyIdle();
            stepCycle("idle");
        end

        applyStimulus(6'd5, 6'd0, 1'b1, 1'b0, 6'd5, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle("hz_ex.detect");
        stepCycle("hz_ex.stall");
        applyIdle();
        stepCycle("hz_ex.resume");
        checkOutput("hz_ex.count", 32'(stall_cycles), 32'd2);

        applyStimulus(6'd0, 6'd9, 1'b0, 1'b1, 6'd3, 1'b1, 6'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle("hz_wb.detect");
        applyIdle();
        stepCycle("hz_wb.resume");

        applyStimulus(6'd5, 6'd0, 1'b1, 1'b0, 6'd5, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle("brz.redirect");
        applyIdle();
        stepCycle("brz.flush");
        stepCycle("brz.after");
        checkOutput("brz.count", 32'(redirect_count), 32'd1);

        applyStimulus(6'd7, 6'd0, 1'b1, 1'b0, 6'd7, 1'b1, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        stepCycle("brn.not_taken");
        applyStimulus(6'd7, 6'd0, 1'b1, 1'b0, 6'd7, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        stepCycle("jump_in_stall");
        applyIdle();
        stepCycle("jump_in_stall.flush");
        stepCycle("jump_in_stall.after");

        applyStimulus(6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        stepCycle("flush_rst.redirect");
        applyIdle();
        doReset("flush_rst");
        stepCycle("flush_rst.after");

        for (int i = 0; i < 400; i++) begin
            logic [RW-1:0] rs, rt, erd, wrd;
            rs  = ($urandom_range(0, 7) == 0) ? RW'($urandom) : RW'($urandom_range(0, 3));
            rt  = RW'($urandom_range(0, 3));
            erd = RW'($urandom_range(0, 3));
            wrd = ($urandom_range(0, 7) == 0) ? RW'($urandom) : RW'($urandom_range(0, 3));
            applyStimulus(rs, rt, 1'($urandom), 1'($urandom), erd, 1'($urandom),
                          wrd, 1'($urandom), $urandom_range(0, 3) == 0, 1'($urandom),
                          $urandom_range(0, 9) == 0, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 49) == 0)
                doReset("rand");
            else
                stepCycle("rand");
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
